// File: rtl/shifter_stage_pkg.sv
// Shared types and constants for the operand/shifter stage feeding the ALU.
// Build option SHIFTER_REGSHIFT_EN (see shifter_stage.sv) selects register-specified shift support.
package shifter_stage_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned SHAMT_W    = 8;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned IMM8_W     = 8;
  localparam int unsigned ROT_W      = 4;

  localparam logic [WORD_WIDTH-1:0] WORD_ZERO = '0;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } sh_type_e;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_RSHIFT = 1'b1
  } state_e;

  // ARM data-processing opcodes carried through to the ALU
  typedef enum logic [OPCODE_W-1:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [WORD_WIDTH-1:0] rn;
    logic [WORD_WIDTH-1:0] op2;
    logic                  carry;
  } alu_req_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [WORD_WIDTH-1:0] rn;
    logic [WORD_WIDTH-1:0] rm;
    sh_type_e              sh_type;
    logic [SHAMT_W-1:0]    amount;
    logic                  carry_in;
  } rshift_op_t;

endpackage

// File: rtl/shifter_stage_barrel_shift.sv
// Combinational 32-bit ARM barrel shifter. imm_enc=1 applies the immediate-shift
// encoding (amount 0 means 32 / RRX); imm_enc=0 applies register-shift rules on an 8-bit amount.
module barrel_shift
  import shifter_stage_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] value,
  input  sh_type_e              sh_type,
  input  logic [SHAMT_W-1:0]    amount,
  input  logic                  imm_enc,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  carry_out
);

  logic [SHIFT_W-1:0]    n;
  logic                  amt_zero;
  logic                  amt_32;
  logic                  amt_over;
  logic                  msb;
  logic [WORD_WIDTH-1:0] sign_fill;
  logic [WORD_WIDTH-1:0] lsl_r;
  logic [WORD_WIDTH-1:0] lsr_r;
  logic [WORD_WIDTH-1:0] asr_r;
  logic [WORD_WIDTH-1:0] ror_r;
  logic                  lsl_c;
  logic                  rsh_c;

  assign n         = amount[SHIFT_W-1:0];
  assign amt_zero  = (amount == '0);
  assign amt_32    = (amount == SHAMT_W'(WORD_WIDTH));
  assign amt_over  = (amount > SHAMT_W'(WORD_WIDTH));
  assign msb       = value[WORD_WIDTH-1];
  assign sign_fill = {WORD_WIDTH{msb}};

  // Primitive results, valid for shift counts 1..31
  assign lsl_r = value << n;
  assign lsr_r = value >> n;
  assign asr_r = $unsigned($signed(value) >>> n);
  assign ror_r = lsr_r | (value << (6'(WORD_WIDTH) - {1'b0, n}));
  assign lsl_c = value[SHIFT_W'(32'(WORD_WIDTH) - 32'(n))];
  assign rsh_c = value[SHIFT_W'(n - SHIFT_W'(1))];

  always_comb begin
    result    = value;
    carry_out = carry_in;
    if (imm_enc) begin
      case (sh_type)
        SH_LSL: begin
          if (n != '0) begin
            result    = lsl_r;
            carry_out = lsl_c;
          end
        end
        SH_LSR: begin
          if (n == '0) begin
            result    = WORD_ZERO;
            carry_out = msb;
          end else begin
            result    = lsr_r;
            carry_out = rsh_c;
          end
        end
        SH_ASR: begin
          if (n == '0) begin
            result    = sign_fill;
            carry_out = msb;
          end else begin
            result    = asr_r;
            carry_out = rsh_c;
          end
        end
        SH_ROR: begin
          if (n == '0) begin
            result    = {carry_in, value[WORD_WIDTH-1:1]};
            carry_out = value[0];
          end else begin
            result    = ror_r;
            carry_out = rsh_c;
          end
        end
      endcase
    end else if (!amt_zero) begin
      case (sh_type)
        SH_LSL: begin
          if (amt_32) begin
            result    = WORD_ZERO;
            carry_out = value[0];
          end else if (amt_over) begin
            result    = WORD_ZERO;
            carry_out = 1'b0;
          end else begin
            result    = lsl_r;
            carry_out = lsl_c;
          end
        end
        SH_LSR: begin
          if (amt_32) begin
            result    = WORD_ZERO;
            carry_out = msb;
          end else if (amt_over) begin
            result    = WORD_ZERO;
            carry_out = 1'b0;
          end else begin
            result    = lsr_r;
            carry_out = rsh_c;
          end
        end
        SH_ASR: begin
          if (amt_32 || amt_over) begin
            result    = sign_fill;
            carry_out = msb;
          end else begin
            result    = asr_r;
            carry_out = rsh_c;
          end
        end
        SH_ROR: begin
          // Multiples of 32 leave the value intact but still produce a carry
          if (n == '0) begin
            result    = value;
            carry_out = msb;
          end else begin
            result    = ror_r;
            carry_out = rsh_c;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_stage.sv
// Operand-2 / shifter pipeline stage in front of the ALU with a registered valid/ready output.
// Define SHIFTER_REGSHIFT_EN to support register-specified shifts (adds the ST_RSHIFT cycle).
module shifter_stage
  import shifter_stage_pkg::*;
#(
  parameter int unsigned WordWidth = WORD_WIDTH
) (
  input  logic                 in_Clk,
  input  logic                 in_nRst,
  input  logic                 in_Valid,
  output logic                 out_Ready,
  input  logic [OPCODE_W-1:0]  in_Opcode,
  input  logic [WordWidth-1:0] in_Rn,
  input  logic [WordWidth-1:0] in_Rm,
  input  logic [WordWidth-1:0] in_Rs,
  input  logic                 in_ImmMode,
  input  logic [IMM8_W-1:0]    in_Imm8,
  input  logic [ROT_W-1:0]     in_Rot4,
  input  logic [1:0]           in_ShType,
  input  logic [SHIFT_W-1:0]   in_ShImm5,
  input  logic                 in_ShReg,
  input  logic                 in_CarryIn,
  output logic                 out_Valid,
  input  logic                 in_Ready,
  output logic [WordWidth-1:0] out_Rn,
  output logic [WordWidth-1:0] out_Op2,
  output logic                 out_Carry,
  output logic [OPCODE_W-1:0]  out_Opcode
);

  alu_req_t              out_q;
  alu_req_t              out_d;
  logic                  out_valid_q;
  logic                  load_en_c;
  logic                  load_out;

  logic [WORD_WIDTH-1:0] sh_value;
  sh_type_e              sh_type;
  logic [SHAMT_W-1:0]    sh_amount;
  logic                  sh_imm_enc;
  logic                  sh_carry_in;
  logic [WORD_WIDTH-1:0] sh_result;
  logic                  sh_carry_out;
  logic [OPCODE_W-1:0]   cur_opcode;
  logic [WORD_WIDTH-1:0] cur_rn;

  // Output slot is free, or its current contents retire this cycle
  assign load_en_c = !out_valid_q || in_Ready;

`ifdef SHIFTER_REGSHIFT_EN
  state_e     state;
  state_e     state_nxt;
  rshift_op_t rsh_q;
  logic       capture;
  logic       unused_rs_hi;

  assign unused_rs_hi = ^in_Rs[WordWidth-1:SHAMT_W];

  always_ff @(posedge in_Clk or negedge in_nRst) begin
    if (!in_nRst) begin
      state <= ST_ACCEPT;
      rsh_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rsh_q <= '{opcode:   in_Opcode,
                   rn:       in_Rn,
                   rm:       in_Rm,
                   sh_type:  sh_type_e'(in_ShType),
                   amount:   in_Rs[SHAMT_W-1:0],
                   carry_in: in_CarryIn};
      end
    end
  end

  // Register shifts latch in the accept cycle and compute in ST_RSHIFT
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_out  = 1'b0;
    out_Ready = 1'b0;
    case (state)
      ST_ACCEPT: begin
        out_Ready = load_en_c;
        if (in_Valid && load_en_c) begin
          if (!in_ImmMode && in_ShReg) begin
            capture   = 1'b1;
            state_nxt = ST_RSHIFT;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      ST_RSHIFT: begin
        if (load_en_c) begin
          load_out  = 1'b1;
          state_nxt = ST_ACCEPT;
        end
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{in_Rs, in_ShReg};
  assign out_Ready     = load_en_c;
  assign load_out      = in_Valid && load_en_c;
`endif

  // Single shifter instance, fed from live inputs or the latched register-shift op
  always_comb begin
    cur_opcode  = in_Opcode;
    cur_rn      = in_Rn;
    sh_carry_in = in_CarryIn;
    if (in_ImmMode) begin
      sh_value   = WORD_WIDTH'(in_Imm8);
      sh_type    = SH_ROR;
      sh_amount  = SHAMT_W'({in_Rot4, 1'b0});
      sh_imm_enc = 1'b0;
    end else begin
      sh_value   = in_Rm;
      sh_type    = sh_type_e'(in_ShType);
      sh_amount  = SHAMT_W'(in_ShImm5);
      sh_imm_enc = 1'b1;
    end
`ifdef SHIFTER_REGSHIFT_EN
    if (state == ST_RSHIFT) begin
      cur_opcode  = rsh_q.opcode;
      cur_rn      = rsh_q.rn;
      sh_carry_in = rsh_q.carry_in;
      sh_value    = rsh_q.rm;
      sh_type     = rsh_q.sh_type;
      sh_amount   = rsh_q.amount;
      sh_imm_enc  = 1'b0;
    end
`endif
  end

  barrel_shift u_barrel_shift (
    .value     (sh_value),
    .sh_type   (sh_type),
    .amount    (sh_amount),
    .imm_enc   (sh_imm_enc),
    .carry_in  (sh_carry_in),
    .result    (sh_result),
    .carry_out (sh_carry_out)
  );

  assign out_d = '{opcode: cur_opcode, rn: cur_rn, op2: sh_result, carry: sh_carry_out};

  always_ff @(posedge in_Clk or negedge in_nRst) begin
    if (!in_nRst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_q       <= out_d;
    end else if (in_Ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_Valid  = out_valid_q;
  assign out_Rn     = out_q.rn;
  assign out_Op2    = out_q.op2;
  assign out_Carry  = out_q.carry;
  assign out_Opcode = out_q.opcode;

endmodule

// File: tb/tb_shifter_stage.sv
// Scoreboard bench for shifter_stage: directed ops push expected results, a monitor checks transfers.
// Register-shift cases are enabled when SHIFTER_REGSHIFT_EN is defined.
module tb_shifter_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [3:0]  in_opcode = '0;
  logic [31:0] in_rn = '0;
  logic [31:0] in_rm = '0;
  logic [31:0] in_rs = '0;
  logic        in_imm_mode = 1'b0;
  logic [7:0]  in_imm8 = '0;
  logic [3:0]  in_rot4 = '0;
  logic [1:0]  in_sh_type = '0;
  logic [4:0]  in_sh_imm5 = '0;
  logic        in_sh_reg = 1'b0;
  logic        in_carry = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b0;
  logic [31:0] out_rn;
  logic [31:0] out_op2;
  logic        out_carry;
  logic [3:0]  out_opcode;

  typedef struct packed {
    logic [31:0] rn;
    logic [31:0] op2;
    logic        c;
    logic [3:0]  opc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pushed = 0;
  int          popped = 0;
  int unsigned seq = 0;

  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;

  shifter_stage dut (
    .in_Clk     (clk),
    .in_nRst    (rst_n),
    .in_Valid   (in_valid),
    .out_Ready  (out_ready),
    .in_Opcode  (in_opcode),
    .in_Rn      (in_rn),
    .in_Rm      (in_rm),
    .in_Rs      (in_rs),
    .in_ImmMode (in_imm_mode),
    .in_Imm8    (in_imm8),
    .in_Rot4    (in_rot4),
    .in_ShType  (in_sh_type),
    .in_ShImm5  (in_sh_imm5),
    .in_ShReg   (in_sh_reg),
    .in_CarryIn (in_carry),
    .out_Valid  (out_valid),
    .in_Ready   (in_ready),
    .out_Rn     (out_rn),
    .out_Op2    (out_op2),
    .out_Carry  (out_carry),
    .out_Opcode (out_opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, then scramble inputs so latching is exercised
  task automatic issue(input logic imm_mode, input logic [7:0] imm8, input logic [3:0] rot4,
                       input logic [1:0] sh_type, input logic [4:0] sh_imm5, input logic sh_reg,
                       input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                       input logic [31:0] e_op2, input logic e_c, input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    seq++;
    in_opcode   = seq[3:0];
    in_rn       = 32'hA500_0000 | seq;
    in_imm_mode = imm_mode;
    in_imm8     = imm8;
    in_rot4     = rot4;
    in_sh_type  = sh_type;
    in_sh_imm5  = sh_imm5;
    in_sh_reg   = sh_reg;
    in_rm       = rm;
    in_rs       = rs;
    in_carry    = cin;
    in_valid    = 1'b1;
    while (!out_ready && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_ready", 32'(out_ready), 32'd1);
    if (out_ready && push) begin
      e.rn  = in_rn;
      e.op2 = e_op2;
      e.c   = e_c;
      e.opc = in_opcode;
      exp_q.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_rm      = ~rm;
    in_rs      = ~rs;
    in_carry   = ~cin;
    in_sh_type = ~sh_type;
    in_imm8    = ~imm8;
    in_rn      = ~in_rn;
    in_opcode  = ~in_opcode;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_op2"}, out_op2, 32'd0);
    chk({tag, "_rn"}, out_rn, 32'd0);
    chk({tag, "_carry"}, 32'(out_carry), 32'd0);
    chk({tag, "_opcode"}, 32'(out_opcode), 32'd0);
    chk({tag, "_ready"}, 32'(out_ready), 32'd1);
  endtask

  // Monitor: every transfer on the ALU side must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && in_ready) begin
        checks++;
        popped++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output rn=%h op2=%h c=%b opc=%h", out_rn, out_op2, out_carry, out_opcode);
        end else begin
          e = exp_q.pop_front();
          if (out_rn !== e.rn || out_op2 !== e.op2 || out_carry !== e.c || out_opcode !== e.opc) begin
            errors++;
            $display("FAIL output_%0d got rn=%h op2=%h c=%b opc=%h exp rn=%h op2=%h c=%b opc=%h",
                     popped, out_rn, out_op2, out_carry, out_opcode, e.rn, e.op2, e.c, e.opc);
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench did not finish");
  end

  initial begin
    #12;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_after_reset", 32'(out_ready), 32'd1);
    in_ready = 1'b1;

    // Rotated immediates
    issue(1'b1, 8'hFF, 4'd4, LSL, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFF00_0000, 1'b1, 1'b1);
    chk("imm_rot_latency", 32'(out_valid), 32'd1);
    issue(1'b1, 8'h55, 4'd0, LSL, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0055, 1'b1, 1'b1);
    issue(1'b1, 8'h01, 4'd1, LSL, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4000_0000, 1'b0, 1'b1);

    // Immediate-shift special encodings
    issue(1'b0, 8'h0, 4'd0, LSR, 5'd0, 1'b0, 32'h8000_0001, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ASR, 5'd0, 1'b0, 32'h8000_0001, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ROR, 5'd0, 1'b0, 32'h8000_0001, 32'h0, 1'b1, 32'hC000_0000, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd0, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 1'b1);

    // Ordinary immediate shifts
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd4, 1'b0, 32'h1F00_0001, 32'h0, 1'b0, 32'hF000_0010, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, LSR, 5'd8, 1'b0, 32'h0000_1280, 32'h0, 1'b0, 32'h0000_0012, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ASR, 5'd4, 1'b0, 32'h8000_0018, 32'h0, 1'b0, 32'hF800_0001, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ROR, 5'd4, 1'b0, 32'h0000_000F, 32'h0, 1'b0, 32'hF000_0000, 1'b1, 1'b1);

    @(posedge clk); #1;
    chk("drained_idle", 32'(out_valid), 32'd0);

    // Backpressure: first output frozen, second op refused until release
    in_ready = 1'b0;
    issue(1'b1, 8'h11, 4'd0, LSL, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0011, 1'b0, 1'b1);
    in_imm_mode = 1'b1;
    in_imm8     = 8'h22;
    in_rot4     = 4'd0;
    in_carry    = 1'b1;
    in_rn       = 32'hB000_0002;
    in_opcode   = 4'h7;
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(out_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_op2", out_op2, 32'h0000_0011);
      @(posedge clk); #1;
    end
    in_ready = 1'b1;
    begin
      exp_t e;
      e.rn  = 32'hB000_0002;
      e.op2 = 32'h0000_0022;
      e.c   = 1'b1;
      e.opc = 4'h7;
      exp_q.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_b2b_valid", 32'(out_valid), 32'd1);
    chk("release_b2b_op2", out_op2, 32'h0000_0022);

`ifdef SHIFTER_REGSHIFT_EN
    // Register-specified shifts
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd0, 1'b1, 32'h0000_0001, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rsh_first_valid", 32'(out_valid), 32'd0);
    chk("rsh_first_ready", 32'(out_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsh_second_valid", 32'(out_valid), 32'd1);
    chk("rsh_second_ready", 32'(out_ready), 32'd1);
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd0, 1'b1, 32'h0000_0001, 32'h21, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 8'h0, 4'd0, LSR, 5'd0, 1'b1, 32'h8000_0000, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ASR, 5'd0, 1'b1, 32'h8000_0000, 32'h40, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, ROR, 5'd0, 1'b1, 32'h8000_0001, 32'h20, 1'b0, 32'h8000_0001, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, LSR, 5'd0, 1'b1, 32'h0000_0005, 32'h00, 1'b1, 32'h0000_0005, 1'b1, 1'b1);
    issue(1'b0, 8'h0, 4'd0, LSR, 5'd0, 1'b1, 32'h0000_00F0, 32'h104, 1'b0, 32'h0000_000F, 1'b0, 1'b1);
    issue(1'b1, 8'h80, 4'd0, LSL, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0080, 1'b0, 1'b1);

    // Reset while in the second cycle of a register shift drops the op
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd0, 1'b1, 32'h0000_0001, 32'h04, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rsh_reset_pre_ready", 32'(out_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rsh_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rsh_reset_no_stale", 32'(out_valid), 32'd0);
    end
`else
    // Shift-by-register request is treated as an immediate shift
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd4, 1'b1, 32'h0000_0001, 32'h21, 1'b0, 32'h0000_0010, 1'b0, 1'b1);
    chk("shreg_ignored_latency", 32'(out_valid), 32'd1);
    chk("shreg_ignored_ready", 32'(out_ready), 32'd1);
`endif

    // Reset with a stalled valid output drops it
    @(posedge clk); #1;
    in_ready = 1'b0;
    issue(1'b0, 8'h0, 4'd0, LSL, 5'd1, 1'b0, 32'h0000_0003, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_reset_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("stall_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_reset_no_stale", 32'(out_valid), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("outputs_seen", 32'(popped), 32'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
